// File: rtl/host_bfm_tag_pool.sv
// Free-tag pool for the host BFM: a circular free-list FIFO seeded with every tag
// at reset, plus an in-use bitmap that screens releases for range and double-free errors.
module host_bfm_tag_pool #(
    parameter int TAG_WIDTH = 10,
    parameter int NUM_TAGS  = 256,
    parameter int CNT_WIDTH = $clog2(NUM_TAGS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 alloc_valid,
    input  logic                 alloc_ready,
    output logic [TAG_WIDTH-1:0] alloc_tag,
    input  logic                 rel_valid,
    input  logic [TAG_WIDTH-1:0] rel_tag,
    output logic                 init_done,
    output logic [CNT_WIDTH-1:0] outstanding,
    output logic                 err_double_free,
    output logic                 err_range,
    output logic                 dbg_state
);
    // Handshake: a tag moves to the requester on any rising edge where alloc_valid and
    // alloc_ready are both high; alloc_tag holds steady while alloc_valid waits for ready.
    // rel_valid has no back-pressure: every release is accepted or flagged the next cycle.

    localparam int IDX_W = (NUM_TAGS > 2) ? $clog2(NUM_TAGS) : 1;
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_TAGS - 1);
    localparam logic [IDX_W-1:0]     IDX_ONE  = IDX_W'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [TAG_WIDTH-1:0] fifo_mem [NUM_TAGS];
    logic [IDX_W-1:0]     rd_ptr;
    logic [IDX_W-1:0]     wr_ptr;
    logic [CNT_WIDTH-1:0] depth;
    logic [NUM_TAGS-1:0]  in_use;

    logic [IDX_W-1:0]     rel_idx;
    logic [IDX_W-1:0]     head_idx;
    logic                 rel_in_range;
    logic                 rel_in_use;
    logic                 pop;
    logic                 push;
    logic                 init_wr;
    logic                 rel_legal;
    logic                 rel_dbl;
    logic                 rel_oor;
    logic [TAG_WIDTH-1:0] push_tag;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] p);
        return (p == LAST_IDX) ? '0 : p + IDX_ONE;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_INIT;
        else     state_q <= state_d;
    end

    // INIT seeds one tag per cycle using wr_ptr as the tag value; it ends on the last slot.
    always_comb begin
        state_d     = state_q;
        alloc_valid = 1'b0;
        init_done   = 1'b0;
        init_wr     = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_wr = 1'b1;
                if (wr_ptr == LAST_IDX) state_d = ST_READY;
            end
            ST_READY: begin
                init_done   = 1'b1;
                alloc_valid = (depth != '0);
            end
            default: state_d = ST_INIT;
        endcase
    end

    assign dbg_state = state_q;
    assign alloc_tag = fifo_mem[rd_ptr];
    assign head_idx  = alloc_tag[IDX_W-1:0];

    assign rel_idx      = rel_tag[IDX_W-1:0];
    assign rel_in_range = (32'(rel_tag) < NUM_TAGS);
    assign rel_in_use   = in_use[rel_idx];

    // The in-use bit is sampled before this edge's pop, so releasing the head tag in
    // the cycle it is handed out counts as a double free.
    assign pop       = alloc_valid & alloc_ready;
    assign rel_legal = init_done & rel_valid & rel_in_range & rel_in_use;
    assign rel_dbl   = init_done & rel_valid & rel_in_range & ~rel_in_use;
    assign rel_oor   = init_done & rel_valid & ~rel_in_range;
    assign push      = init_wr | rel_legal;
    assign push_tag  = init_wr ? TAG_WIDTH'(wr_ptr) : rel_tag;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            depth           <= '0;
            in_use          <= '0;
            outstanding     <= '0;
            err_double_free <= 1'b0;
            err_range       <= 1'b0;
        end else begin
            err_double_free <= rel_dbl;
            err_range       <= rel_oor;
            if (push) wr_ptr <= next_idx(wr_ptr);
            if (pop)  rd_ptr <= next_idx(rd_ptr);
            if (push && !pop)      depth <= depth + CNT_ONE;
            else if (pop && !push) depth <= depth - CNT_ONE;
            // A legal release always names an allocated tag, never the free head.
            if (pop)       in_use[head_idx] <= 1'b1;
            if (rel_legal) in_use[rel_idx]  <= 1'b0;
            if (pop && !rel_legal)      outstanding <= outstanding + CNT_ONE;
            else if (rel_legal && !pop) outstanding <= outstanding - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= push_tag;
    end

endmodule

// File: doc/host_bfm_tag_pool.md
HOST_BFM_TAG_POOL -- requirements
Module: host_bfm_tag_pool

Interface
REQ-001 SHALL have parameter TAG_WIDTH, default 10, giving the tag width (matches packet_tag_t).
REQ-002 SHALL have parameter NUM_TAGS, default 256, giving the pool size; legal range 2..2**TAG_WIDTH.
REQ-003 SHALL have parameter CNT_WIDTH, default $clog2(NUM_TAGS+1), giving the occupancy counter width.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port alloc_valid, output, 1, meaning a free tag is offered.
REQ-007 SHALL have port alloc_ready, input, 1, meaning the requester takes the offered tag.
REQ-008 SHALL have port alloc_tag, output, TAG_WIDTH, the offered tag.
REQ-009 SHALL have port rel_valid, input, 1, meaning a tag is returned this cycle.
REQ-010 SHALL have port rel_tag, input, TAG_WIDTH, the returned tag.
REQ-011 SHALL have port init_done, output, 1, meaning the free list is populated.
REQ-012 SHALL have port outstanding, output, CNT_WIDTH, the number of tags currently allocated.
REQ-013 SHALL have port err_double_free, output, 1, a one-cycle pulse on release of a non-allocated tag.
REQ-014 SHALL have port err_range, output, 1, a one-cycle pulse on release of a tag >= NUM_TAGS.

Function
REQ-015 SHALL implement states INIT and READY; reset enters INIT.
REQ-016 INIT SHALL write tags 0..NUM_TAGS-1 into a free-list FIFO, one tag per cycle, in ascending order; after the last write it transitions to READY, taking exactly NUM_TAGS cycles.
REQ-017 In INIT: alloc_valid=0, init_done=0, rel_valid ignored, no error pulses.
REQ-018 In READY: init_done=1; alloc_valid=1 when the FIFO is non-empty, else 0.
REQ-019 alloc_tag SHALL equal the FIFO head whenever alloc_valid=1, and SHALL stay stable until the handshake.
REQ-020 Handshake: alloc_valid&alloc_ready at edge -> pop head, set the in-use bit for that tag, outstanding+1.
REQ-021 alloc_ready while alloc_valid=0 SHALL have no effect.
REQ-022 Legal release (READY, rel_valid, rel_tag<NUM_TAGS, in-use bit set) -> push rel_tag at the FIFO tail, clear its in-use bit, outstanding-1.
REQ-023 Release with rel_tag>=NUM_TAGS -> err_range=1 the next cycle; no state change.
REQ-024 Release of an in-range tag whose in-use bit is clear -> err_double_free=1 the next cycle; no state change.
REQ-025 Simultaneous pop and legal release in one cycle SHALL both take effect; outstanding unchanged.
REQ-026 A released tag SHALL NOT be offered in its release cycle; it is earliest visible on alloc_tag in the cycle after the release edge, and only when the FIFO was empty.
REQ-027 Simultaneous allocation of tag T and release of the same tag T is a double free (the in-use bit is sampled before update): err_double_free pulses and the tag becomes allocated.
REQ-028 Allocation order SHALL be FIFO (least recently released first).
REQ-029 FIFO pointers SHALL wrap modulo NUM_TAGS; a depth counter distinguishes full from empty; the FIFO can never overflow because only legal releases push.
REQ-030 outstanding SHALL remain in 0..NUM_TAGS and never wrap.

Reset
REQ-031 rst at any edge, including mid-INIT or mid-traffic: state=INIT, pointers=0, depth=0, in-use bitmap all clear, outstanding=0, alloc_valid=0, init_done=0, err_double_free=0, err_range=0.
REQ-032 Tags held by requesters across reset SHALL be considered free; their releases after reset return err_double_free.

Verification
REQ-033 Reset, then NUM_TAGS=256 -> init_done rises exactly 256 cycles after rst deasserts; the first allocs return 0,1,2,... in order.
REQ-034 Allocate all 256 with alloc_ready held at 1 -> alloc_valid=0 and outstanding=256; release tag 17 -> the next cycle alloc_valid=1, alloc_tag=17, outstanding=255.
REQ-035 With 3 outstanding, pop tag 3 while releasing tag 1 in the same cycle -> outstanding stays 3; tag 1 is queued behind tags 4..255.
REQ-036 Release tag 300 -> err_range pulses for one cycle; release an unallocated tag 5 -> err_double_free pulses; outstanding unchanged in both cases.
REQ-037 Assert rst at INIT cycle 100 and after 50 allocations -> full INIT restarts; releasing a tag allocated before the reset pulses err_double_free.
REQ-038 Random alloc_ready/release traffic for 100k cycles -> no tag is ever offered while allocated, outstanding equals the scoreboard count, and no error pulses occur for legal traffic.
